// File: rtl/bch_enc.sv
// bch_enc : systematic binary BCH encoder, bit-serial message in, 64-bit beats out.
//
// Supports the (63,51) t=2, (255,239) t=2 and (1023,983) t=4 codes. Each frame
// holds N = n+1 positions. The top position is a zero pad. The message follows
// it, highest position first, and the r parity bits come last. Every position
// is emitted as one 8-bit hard LLR symbol (7F = 0, 81 = 1). Eight symbols are
// packed per beat, and the earliest symbol of the beat sits in dout_o[63:56].
//
// Ports
//   clk_i, rst_i             clock, synchronous active-high reset
//   start_i, code_i          frame request and code select, both sampled in IDLE
//                            code: 1=(63,51) 2=(255,239) 3 or 0=(1023,983)
//   din_i, din_valid_i,      message bit stream; a bit is taken on valid & ready
//   din_ready_o
//   dout_o, dout_valid_o,    beat stream; a beat is taken on valid & ready
//   dout_ready_i
//   busy_o                   a frame is in progress
//   done_o                   pulse on the handshake of the last beat

// Symbol packer: collects 8 symbols and hands them to the output register.
module bch_enc_beat #(
  parameter logic [7:0] LLR_ZERO = 8'h7F,
  parameter logic [7:0] LLR_ONE  = 8'h81
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        clr_i,         // frame start: restart the symbol count
  input  logic        sym_v_i,       // a symbol is produced this cycle
  input  logic        sym_i,         // its bit value
  input  logic        dout_ready_i,
  output logic        stall_o,       // 8th symbol would overwrite a pending beat
  output logic [63:0] dout_o,
  output logic        dout_valid_o
);

  logic [2:0]  sc_q, sc_d;
  logic [55:0] sr_q, sr_d;           // the 7 earlier symbols of the current beat
  logic [63:0] dout_q, dout_d;
  logic        dv_q, dv_d;
  logic [7:0]  sym_byte;

  assign sym_byte = sym_i ? LLR_ONE : LLR_ZERO;

  // The output register is checked only when the 8th symbol arrives.
  // Symbols 1..7 can still be collected while an earlier beat waits.
  assign stall_o = (sc_q == 3'd7) && dv_q && !dout_ready_i;

  always_comb begin
    sc_d   = sc_q;
    sr_d   = sr_q;
    dout_d = dout_q;
    dv_d   = dv_q && !dout_ready_i;
    if (clr_i) begin
      sc_d = '0;
    end else if (sym_v_i) begin
      if (sc_q == 3'd7) begin
        // A load in the same cycle as a handshake keeps valid high.
        dout_d = {sr_q, sym_byte};
        dv_d   = 1'b1;
        sc_d   = '0;
      end else begin
        sr_d = {sr_q[47:0], sym_byte};
        sc_d = sc_q + 3'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sc_q   <= '0;
      sr_q   <= '0;
      dout_q <= '0;
      dv_q   <= 1'b0;
    end else begin
      sc_q   <= sc_d;
      sr_q   <= sr_d;
      dout_q <= dout_d;
      dv_q   <= dv_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dv_q;

endmodule

module bch_enc #(
  parameter logic [7:0] LLR_ZERO = 8'h7F,
  parameter logic [7:0] LLR_ONE  = 8'h81
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        start_i,
  input  logic [1:0]  code_i,
  input  logic        din_i,
  input  logic        din_valid_i,
  output logic        din_ready_o,
  output logic [63:0] dout_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic        busy_o,
  output logic        done_o
);

  // Carry-less (GF(2)) polynomial product. It is used only to build g(x).
  function automatic logic [40:0] clmul(input logic [40:0] a, input logic [40:0] b);
    logic [40:0] p;
    p = '0;
    for (int i = 0; i < 41; i++)
      if (b[i]) p = p ^ (a << i);
    return p;
  endfunction

  localparam logic [12:0] G63   = 13'h1539;
  localparam logic [16:0] G255  = 17'h16F63;
  // g(x) for (1023,983): product of the minimal polynomials of a, a^3, a^5, a^7.
  localparam logic [40:0] G1023 = clmul(clmul(clmul(41'o2011, 41'o2415), 41'o3771), 41'o2157);

  typedef enum logic [2:0] {S_IDLE, S_PAD, S_MSG, S_PAR, S_FLUSH} state_t;

  state_t      state_q;
  logic [1:0]  code_q;
  logic [39:0] lfsr_q;
  logic [9:0]  cnt_q;                // message / parity bit counter

  // Code geometry decoded from the latched select. 0 aliases the long code.
  logic [5:0]  r_sel;
  logic [9:0]  k_sel;
  logic [39:0] g_low;                // g(x) without its leading x^r term
  logic [39:0] r_mask;

  always_comb begin
    case (code_q)
      2'd1: begin
        r_sel  = 6'd12;
        k_sel  = 10'd51;
        g_low  = {28'd0, G63[11:0]};
        r_mask = 40'h0000000FFF;
      end
      2'd2: begin
        r_sel  = 6'd16;
        k_sel  = 10'd239;
        g_low  = {24'd0, G255[15:0]};
        r_mask = 40'h000000FFFF;
      end
      default: begin
        r_sel  = 6'd40;
        k_sel  = 10'd983;
        g_low  = G1023[39:0];
        r_mask = 40'hFFFFFFFFFF;
      end
    endcase
  end

  logic        stall;
  logic        sym_v, sym_b;
  logic        lfsr_msb, fb;
  logic [39:0] lfsr_div, lfsr_shift;
  logic        beat_hs;
  logic        dv;

  assign lfsr_msb   = lfsr_q[r_sel - 6'd1];
  assign fb         = din_i ^ lfsr_msb;
  // One step of dividing m(x)*x^r by g(x).
  assign lfsr_div   = ((lfsr_q << 1) ^ (fb ? g_low : 40'd0)) & r_mask;
  // Parity readout: shift out the MSB and fill with zero.
  assign lfsr_shift = (lfsr_q << 1) & r_mask;

  always_comb begin
    sym_v = 1'b0;
    sym_b = 1'b0;
    case (state_q)
      S_PAD: sym_v = !stall;
      S_MSG: begin
        sym_v = din_valid_i && !stall;
        sym_b = din_i;
      end
      S_PAR: begin
        sym_v = !stall;
        sym_b = lfsr_msb;
      end
      default: ;
    endcase
  end

  bch_enc_beat #(
    .LLR_ZERO (LLR_ZERO),
    .LLR_ONE  (LLR_ONE)
  ) u_beat (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clr_i        ((state_q == S_IDLE) && start_i),
    .sym_v_i      (sym_v),
    .sym_i        (sym_b),
    .dout_ready_i (dout_ready_i),
    .stall_o      (stall),
    .dout_o       (dout_o),
    .dout_valid_o (dv)
  );

  assign beat_hs = dv && dout_ready_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      code_q  <= '0;
      lfsr_q  <= '0;
      cnt_q   <= '0;
    end else begin
      case (state_q)
        S_IDLE: if (start_i) begin
          state_q <= S_PAD;
          code_q  <= code_i;
          lfsr_q  <= '0;
          cnt_q   <= '0;
        end
        S_PAD: if (sym_v) state_q <= S_MSG;
        S_MSG: if (sym_v) begin
          lfsr_q <= lfsr_div;
          if (cnt_q == k_sel - 10'd1) begin
            cnt_q   <= '0;
            state_q <= S_PAR;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        S_PAR: if (sym_v) begin
          lfsr_q <= lfsr_shift;
          if (cnt_q == {4'd0, r_sel} - 10'd1) begin
            cnt_q   <= '0;
            state_q <= S_FLUSH;
          end else begin
            cnt_q <= cnt_q + 10'd1;
          end
        end
        // The last parity symbol loads the final beat. Any earlier beat has
        // already been taken, so the next handshake ends the frame.
        S_FLUSH: if (beat_hs) state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign dout_valid_o = dv;
  assign din_ready_o  = (state_q == S_MSG) && !stall;
  assign busy_o       = (state_q != S_IDLE);
  assign done_o       = (state_q == S_FLUSH) && beat_hs;

endmodule

// File: tb/tb_bch_enc.sv
// Self-checking bench for bch_enc. A reference model builds each frame by
// polynomial long division over bit arrays. Received frames are also checked
// for a zero first syndrome in GF(2^m).
module tb_bch_enc;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  code = 2'd0;
  logic        din = 1'b0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic [63:0] dout;
  logic        dout_valid;
  logic        dout_ready = 1'b0;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  bch_enc dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .start_i      (start),
    .code_i       (code),
    .din_i        (din),
    .din_valid_i  (din_valid),
    .din_ready_o  (din_ready),
    .dout_o       (dout),
    .dout_valid_o (dout_valid),
    .dout_ready_i (dout_ready),
    .busy_o       (busy),
    .done_o       (done)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  bit          msg_b[1023];
  logic [63:0] exp_b[128];
  logic [63:0] got_b[128];

  function automatic void geo(input logic [1:0] c, output int N, output int k,
                              output int r, output int m, output int prim);
    case (c)
      2'd1:    begin N = 64;   k = 51;  r = 12; m = 6;  prim = 'h43;  end
      2'd2:    begin N = 256;  k = 239; r = 16; m = 8;  prim = 'h11D; end
      default: begin N = 1024; k = 983; r = 40; m = 10; prim = 'h409; end
    endcase
  endfunction

  function automatic logic [63:0] pmul(input logic [63:0] a, input logic [63:0] b);
    logic [63:0] p = '0;
    for (int i = 0; i < 32; i++)
      if (b[i]) p = p ^ (a << i);
    return p;
  endfunction

  function automatic logic [63:0] gen_poly(input logic [1:0] c);
    case (c)
      2'd1:    return 64'h1539;
      2'd2:    return 64'h16F63;
      default: return pmul(pmul(pmul(64'o2011, 64'o2415), 64'o3771), 64'o2157);
    endcase
  endfunction

  // The codeword is [pad | message | m(x)x^r mod g(x)], indexed by position.
  function automatic void build_expected(input logic [1:0] c);
    int N, k, r, m, prim, n;
    bit fr[1024];
    bit rem[1024];
    logic [63:0] g, beat;
    geo(c, N, k, r, m, prim);
    n = N - 1;
    g = gen_poly(c);
    for (int p = 0; p < 1024; p++) fr[p] = 1'b0;
    for (int i = 0; i < k; i++) fr[n-1-i] = msg_b[i];
    for (int p = 0; p < 1024; p++) rem[p] = fr[p];
    for (int p = n - 1; p >= r; p--)
      if (rem[p])
        for (int d = 0; d <= r; d++)
          if (g[d]) rem[p-r+d] = ~rem[p-r+d];
    for (int p = 0; p < r; p++) fr[p] = rem[p];
    for (int j = 0; j < N / 8; j++) begin
      beat = '0;
      for (int s = 0; s < 8; s++)
        beat[63-8*s -: 8] = fr[N-1-8*j-s] ? 8'h81 : 8'h7F;
      exp_b[j] = beat;
    end
  endfunction

  // c(alpha) by Horner over the received symbols. The pad position is skipped.
  // Any symbol that is not 7F or 81 forces a nonzero result.
  function automatic int synd1(input int N, input int m, input int prim);
    int s = 0;
    logic [7:0] sym;
    for (int j = 0; j < N / 8; j++)
      for (int q = 0; q < 8; q++) begin
        sym = got_b[j][63-8*q -: 8];
        if (sym != 8'h81 && sym != 8'h7F) return -1;
        if (N - 1 - 8*j - q < N - 1) begin
          s = s << 1;
          if ((s >> m) & 1) s = s ^ prim;
          s = s ^ int'(sym == 8'h81);
        end
      end
    return s;
  endfunction

  task automatic run_frame(input logic [1:0] c, input int vpct, input bit hold,
                           input bit restart, input string nm);
    int N, k, r, m, prim, nbeat;
    int idx = 0, nb = 0, t = 0, extra = 0, stab_err = 0, done_err = 0, done_t = -1;
    int hold_left = 0, acc_hold = 0;
    bit hold_seen = 0, held = 0, prev_held = 0, fin = 0, hs;
    logic last_hold_rdy = 1'b1;
    logic [63:0] prev = '0;
    geo(c, N, k, r, m, prim);
    nbeat = N / 8;
    build_expected(c);
    @(posedge clk); #1;
    code = c; start = 1'b1; din_valid = 1'b0; din = 1'b0; dout_ready = 1'b1;
    while (!fin && t < 4 * N + 200) begin
      if (t > 0) begin
        @(posedge clk); #1;
        code  = 2'($urandom);
        start = restart && (t == 20 || (dout_valid && nb == nbeat - 1));
        held  = 1'b0;
        if (hold && !hold_seen && dout_valid) begin hold_seen = 1'b1; hold_left = 20; end
        if (hold_left > 0) begin held = 1'b1; hold_left--; end
        dout_ready = !held;
        din_valid  = held ? 1'b1 : ($urandom_range(0, 99) < vpct);
        din        = (din_valid && idx < k) ? msg_b[idx] : 1'($urandom);
      end
      @(negedge clk);
      if (din_valid && din_ready) begin
        if (idx < k) idx++; else extra++;
        if (held) acc_hold++;
      end
      if (held && hold_left == 0) last_hold_rdy = din_ready;
      if (prev_held && (!dout_valid || dout !== prev)) stab_err++;
      prev_held = dout_valid && !dout_ready;
      prev = dout;
      hs = dout_valid && dout_ready;
      if (hs) begin
        if (nb < nbeat) begin
          got_b[nb] = dout;
          chk($sformatf("%s beat%0d", nm, nb), dout, exp_b[nb]);
        end
        nb++;
      end
      if (done !== (hs && nb == nbeat)) done_err++;
      if (hs && nb == nbeat) begin fin = 1'b1; done_t = t; end
      t++;
    end
    chk({nm, " finished"}, 64'(fin), 64'd1);
    chk({nm, " beat count"}, 64'(nb), 64'(nbeat));
    chk({nm, " stable while held"}, 64'(stab_err), 64'd0);
    chk({nm, " done pulse"}, 64'(done_err), 64'd0);
    chk({nm, " din outside msg"}, 64'(extra), 64'd0);
    if (fin) chk({nm, " syndrome S1"}, 64'(synd1(N, m, prim)), 64'd0);
    if (hold) begin
      chk({nm, " bits taken in hold"}, 64'(acc_hold), 64'd7);
      chk({nm, " din_ready in stall"}, 64'(last_hold_rdy), 64'd0);
    end
    if (vpct >= 100 && !hold) chk({nm, " latency"}, 64'(done_t), 64'(N + 1));
    @(posedge clk); #1;
    start = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk({nm, " busy after done"}, 64'(busy), 64'd0);
  endtask

  task automatic clear_msg();
    for (int i = 0; i < 1023; i++) msg_b[i] = 1'b0;
  endtask

  task automatic rand_msg();
    for (int i = 0; i < 1023; i++) msg_b[i] = 1'($urandom);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int dn;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset dout", dout, 64'd0);
    chk("reset dout_valid", 64'(dout_valid), 64'd0);
    chk("reset din_ready", 64'(din_ready), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);

    // All-zero message.
    clear_msg();
    run_frame(2'd1, 100, 1'b0, 1'b0, "zero63");
    chk("zero63 beat0 const", got_b[0], 64'h7F7F7F7F7F7F7F7F);
    chk("zero63 beat7 const", got_b[7], 64'h7F7F7F7F7F7F7F7F);

    // A single 1 in the last message bit gives codeword = g(x).
    clear_msg(); msg_b[50] = 1'b1;
    run_frame(2'd1, 100, 1'b0, 1'b0, "g63");
    chk("g63 beat5", got_b[5], 64'h7F7F7F7F7F7F7F7F);
    chk("g63 beat6", got_b[6], 64'h7F7F7F817F817F81);
    chk("g63 beat7", got_b[7], 64'h7F7F8181817F7F81);

    // Same frame with a 20-cycle sink hold after beat 1 and random gaps.
    run_frame(2'd1, 70, 1'b1, 1'b0, "g63hold");
    chk("g63hold beat6", got_b[6], 64'h7F7F7F817F817F81);
    chk("g63hold beat7", got_b[7], 64'h7F7F8181817F7F81);

    clear_msg(); msg_b[238] = 1'b1;
    run_frame(2'd2, 100, 1'b0, 1'b0, "g255");
    chk("g255 beat28", got_b[28], 64'h7F7F7F7F7F7F7F7F);
    chk("g255 beat29", got_b[29], 64'h7F7F7F7F7F7F7F81);
    chk("g255 beat30", got_b[30], 64'h7F81817F81818181);
    chk("g255 beat31", got_b[31], 64'h7F81817F7F7F8181);

    for (int i = 0; i < 3; i++) begin
      rand_msg(); run_frame(2'd1, $urandom_range(50, 100), 1'b0, 1'b0, $sformatf("r63_%0d", i));
      rand_msg(); run_frame(2'd2, $urandom_range(50, 100), 1'b0, 1'b0, $sformatf("r255_%0d", i));
    end
    for (int i = 0; i < 12; i++) begin
      rand_msg(); run_frame(2'd3, (i == 0) ? 100 : $urandom_range(60, 100), 1'b0, 1'b0, $sformatf("r1023c3_%0d", i));
      rand_msg(); run_frame(2'd0, $urandom_range(60, 100), 1'b0, 1'b0, $sformatf("r1023c0_%0d", i));
    end

    // start while busy, including in the done cycle, must be ignored.
    rand_msg();
    run_frame(2'd1, 100, 1'b0, 1'b1, "restart");

    // Reset in the middle of MSG.
    @(posedge clk); #1;
    start = 1'b1; code = 2'd2; dout_ready = 1'b1; din_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; din_valid = 1'b1;
    repeat (30) begin
      din = 1'($urandom);
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; din_valid = 1'b0;
    @(negedge clk);
    chk("midrst dout", dout, 64'd0);
    chk("midrst dout_valid", 64'(dout_valid), 64'd0);
    chk("midrst din_ready", 64'(din_ready), 64'd0);
    chk("midrst busy", 64'(busy), 64'd0);
    chk("midrst done", 64'(done), 64'd0);
    dn = 0;
    repeat (60) begin
      @(negedge clk);
      if (done || busy || dout_valid) dn++;
    end
    chk("midrst quiet after", 64'(dn), 64'd0);

    rand_msg();
    run_frame(2'd1, 80, 1'b0, 1'b0, "post_rst");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
